// File: rtl/sw_pkg.sv
// Shared constants for the switch-input conditioning stage.
//   N_SW_DEFAULT      : number of switch bits fed to the CPU
//   DB_CYCLES_DEFAULT : debounce acceptance length in clock cycles
//   HS_BIT            : index of the handshake ("data ready") switch
package sw_pkg;
    localparam int N_SW_DEFAULT      = 9;
    localparam int DB_CYCLES_DEFAULT = 16;
    localparam int HS_BIT            = N_SW_DEFAULT - 1;
endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a debounce counter and
// the accepted (stable) level.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   raw    : asynchronous raw switch level
//   stable : debounced level
//   accept : high in the cycle whose rising edge loads a new stable level
module debounce_bit
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic accept
);
    localparam int CNT_W = $clog2(DB_CYCLES);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The synchronised level has differed from stable for DB_CYCLES-1
    // edges already; this edge makes it DB_CYCLES and takes the new level.
    assign accept = (sync2_reg != stable_reg) && (cnt_reg == CNT_W'(DB_CYCLES - 1));
    assign stable = stable_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == stable_reg) begin
                // Any return to the stable level discards the partial count.
                cnt_reg <= '0;
            end else if (accept) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sw_conditioner.sv
// Input conditioning for the picoMIPS switch bus: per-bit synchronise and
// debounce, plus single-cycle edge pulses on the handshake bit (MSB).
// Optional build macro SW_CONDITIONER_CAPTURE_EN: when defined, the data bits
// of sw are a register loaded from the debounced data bits only when a
// handshake rise is accepted; otherwise all bits follow the debounced levels.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-high reset
//   sw_raw  : raw board switch levels
//   sw      : conditioned switch bus to the CPU
//   hs_rise : one-cycle pulse coincident with sw[N_SW-1] going 0->1
//   hs_fall : one-cycle pulse coincident with sw[N_SW-1] going 1->0
module sw_conditioner
    import sw_pkg::*;
#(
    parameter int N_SW      = N_SW_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw,
    output logic            hs_rise,
    output logic            hs_fall
);
    localparam int HS = N_SW - 1;

    logic [N_SW-1:0] stable;
    logic [N_SW-1:0] accept;
    logic            hs_rise_reg;
    logic            hs_fall_reg;
    logic            hs_rise_next;
    logic            hs_fall_next;
    logic            unused_accept;

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
            debounce_bit #(
                .DB_CYCLES(DB_CYCLES)
            ) u_bit (
                .clk    (clk),
                .reset  (reset),
                .raw    (sw_raw[gi]),
                .stable (stable[gi]),
                .accept (accept[gi])
            );
        end
    endgenerate

    // Acceptance always flips the stable level, so the direction of the
    // edge is the inverse of the level held before this edge.
    assign hs_rise_next = accept[HS] && !stable[HS];
    assign hs_fall_next = accept[HS] &&  stable[HS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_rise_reg <= 1'b0;
            hs_fall_reg <= 1'b0;
        end else begin
            hs_rise_reg <= hs_rise_next;
            hs_fall_reg <= hs_fall_next;
        end
    end

    assign hs_rise       = hs_rise_reg;
    assign hs_fall       = hs_fall_reg;
    assign unused_accept = ^accept[HS-1:0];

`ifdef SW_CONDITIONER_CAPTURE_EN
    logic [HS-1:0] capture_reg;

    // Data byte is frozen at the handshake: take the debounced data bits
    // as they stand when the rising handshake is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capture_reg <= '0;
        end else if (hs_rise_next) begin
            capture_reg <= stable[HS-1:0];
        end
    end

    assign sw = {stable[HS], capture_reg};
`else
    assign sw = stable;
`endif
endmodule
